// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for LEGv8 control: opcode match patterns, opcode
// classes, multi-cycle FSM states and the aluop/signop encodings.
package legv8_ctrl_pkg;

  localparam int OPCODE_W = 11;
  localparam int ALUOP_W  = 4;
  localparam int SIGNOP_W = 3;

  // A casez-style pattern held as value/care-mask pair (mask bit 0 = don't care)
  typedef struct packed {
    logic [OPCODE_W-1:0] value;
    logic [OPCODE_W-1:0] mask;
  } op_pat_t;

  localparam op_pat_t PAT_SUBIMM = '{value: 11'b11010001000, mask: 11'b11111111110};
  localparam op_pat_t PAT_B      = '{value: 11'b00010100000, mask: 11'b11111100000};
  localparam op_pat_t PAT_CBZ    = '{value: 11'b10110100000, mask: 11'b11111111000};
  localparam op_pat_t PAT_LDUR   = '{value: 11'b11111000010, mask: 11'b11111111111};
  localparam op_pat_t PAT_ANDREG = '{value: 11'b10001010000, mask: 11'b11111111111};
  localparam op_pat_t PAT_ORRREG = '{value: 11'b10101010000, mask: 11'b11111111111};
  localparam op_pat_t PAT_ADDREG = '{value: 11'b10001011000, mask: 11'b11111111111};
  localparam op_pat_t PAT_SUBREG = '{value: 11'b11001011000, mask: 11'b11111111111};
  localparam op_pat_t PAT_ADDIMM = '{value: 11'b10010001000, mask: 11'b11111111110};
  localparam op_pat_t PAT_STUR   = '{value: 11'b11111000000, mask: 11'b11111111111};
  localparam op_pat_t PAT_MOVZ   = '{value: 11'b11010010100, mask: 11'b11111111100};

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_SUBIMM  = 4'd1,
    CLS_B       = 4'd2,
    CLS_CBZ     = 4'd3,
    CLS_LDUR    = 4'd4,
    CLS_ANDREG  = 4'd5,
    CLS_ORRREG  = 4'd6,
    CLS_ADDREG  = 4'd7,
    CLS_SUBREG  = 4'd8,
    CLS_ADDIMM  = 4'd9,
    CLS_STUR    = 4'd10,
    CLS_MOVZ    = 4'd11
  } op_class_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  localparam logic [ALUOP_W-1:0] ALU_AND   = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALU_ORR   = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_ADD   = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 4'b0110;
  localparam logic [ALUOP_W-1:0] ALU_PASSB = 4'b0111;

  localparam logic [SIGNOP_W-1:0] SIGN_I  = 3'b000;
  localparam logic [SIGNOP_W-1:0] SIGN_D  = 3'b001;
  localparam logic [SIGNOP_W-1:0] SIGN_B  = 3'b010;
  localparam logic [SIGNOP_W-1:0] SIGN_CB = 3'b011;
  localparam logic [SIGNOP_W-1:0] SIGN_IW = 3'b100;

  function automatic logic op_match(input logic [OPCODE_W-1:0] op, input op_pat_t pat);
    return (op & pat.mask) == pat.value;
  endfunction

endpackage

// File: rtl/legv8_opcode_classify.sv
// Combinational opcode-to-class decoder, shared by multi-cycle and future
// pipelined control. MOVZ is only recognised when MULTICYCLE_CTRL_MOVZ_EN
// is defined; otherwise it falls through to CLS_ILLEGAL.
module legv8_opcode_classify
  import legv8_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_e           op_class
);

  // Priority match, highest-priority pattern first
  always_comb begin
    op_class = CLS_ILLEGAL;
    if      (op_match(opcode, PAT_SUBIMM)) op_class = CLS_SUBIMM;
    else if (op_match(opcode, PAT_B))      op_class = CLS_B;
    else if (op_match(opcode, PAT_CBZ))    op_class = CLS_CBZ;
    else if (op_match(opcode, PAT_LDUR))   op_class = CLS_LDUR;
    else if (op_match(opcode, PAT_ANDREG)) op_class = CLS_ANDREG;
    else if (op_match(opcode, PAT_ORRREG)) op_class = CLS_ORRREG;
    else if (op_match(opcode, PAT_ADDREG)) op_class = CLS_ADDREG;
    else if (op_match(opcode, PAT_SUBREG)) op_class = CLS_SUBREG;
    else if (op_match(opcode, PAT_ADDIMM)) op_class = CLS_ADDIMM;
    else if (op_match(opcode, PAT_STUR))   op_class = CLS_STUR;
`ifdef MULTICYCLE_CTRL_MOVZ_EN
    else if (op_match(opcode, PAT_MOVZ))   op_class = CLS_MOVZ;
`endif
  end

endmodule

// File: rtl/multicycle_control.sv
// LEGv8 multi-cycle control unit: Moore FSM FETCH/DECODE/EXEC/MEM/WB/FAULT
// with instruction/data memory handshakes, memory wait timeout and a
// sticky illegal-opcode fault. Optional MOVZ support: MULTICYCLE_CTRL_MOVZ_EN.
module multicycle_control
  import legv8_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                resetl,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                instr_valid,
  input  logic                mem_ready,
  input  logic                zero,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                reg2loc,
  output logic                alusrc,
  output logic                mem2reg,
  output logic                regwrite,
  output logic                memread,
  output logic                memwrite,
  output logic [ALUOP_W-1:0]  aluop,
  output logic [2:0]          signop,
  output logic [2:0]          state,
  output logic                illegal
);

  // Counter holds completed MEM wait cycles; the last allowed value triggers FAULT
  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  // Low for the first cycle after reset so no strobe follows reset release
  logic                armed_q, armed_d;

  op_class_e           op_class;
  logic                fetch_fire;
  logic [ALUOP_W-1:0]  alu_op_c;
  logic [2:0]          sign_c;
  logic                reg2loc_c;
  logic                alusrc_c;

  legv8_opcode_classify u_classify (
    .opcode   (op_q),
    .op_class (op_class)
  );

  assign fetch_fire = armed_q && instr_valid;

  // State, latched opcode, wait counter and arm flag
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      armed_q <= armed_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    armed_d = 1'b1;
    case (state_q)
      ST_FETCH: begin
        if (fetch_fire) begin
          op_d    = opcode;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = (op_class == CLS_ILLEGAL) ? ST_FAULT : ST_EXEC;
      end
      ST_EXEC: begin
        case (op_class)
          CLS_B, CLS_CBZ: state_d = ST_FETCH;
          CLS_LDUR, CLS_STUR: begin
            state_d = ST_MEM;
            wait_d  = '0;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        // mem_ready has priority over a simultaneous timeout
        if (mem_ready) begin
          state_d = (op_class == CLS_LDUR) ? ST_WB : ST_FETCH;
        end else if (TIMEOUT_EN) begin
          if (wait_q == WAIT_LAST) state_d = ST_FAULT;
          else                     wait_d  = wait_q + CNT_W'(1);
        end
      end
      ST_WB:    state_d = ST_FETCH;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  // ALU/immediate controls implied by the latched instruction class
  always_comb begin
    alu_op_c  = ALU_AND;
    sign_c    = SIGN_I;
    reg2loc_c = 1'b0;
    alusrc_c  = 1'b0;
    case (op_class)
      CLS_ANDREG: alu_op_c = ALU_AND;
      CLS_ORRREG: alu_op_c = ALU_ORR;
      CLS_ADDREG: alu_op_c = ALU_ADD;
      CLS_SUBREG: alu_op_c = ALU_SUB;
      CLS_ADDIMM: begin alu_op_c = ALU_ADD; alusrc_c = 1'b1; end
      CLS_SUBIMM: begin alu_op_c = ALU_SUB; alusrc_c = 1'b1; end
      CLS_LDUR: begin
        alu_op_c = ALU_ADD; alusrc_c = 1'b1; sign_c = SIGN_D;
      end
      CLS_STUR: begin
        alu_op_c = ALU_ADD; alusrc_c = 1'b1; sign_c = SIGN_D; reg2loc_c = 1'b1;
      end
      CLS_CBZ: begin
        alu_op_c = ALU_PASSB; sign_c = SIGN_CB; reg2loc_c = 1'b1;
      end
      CLS_B: sign_c = SIGN_B;
`ifdef MULTICYCLE_CTRL_MOVZ_EN
      CLS_MOVZ: begin
        alu_op_c = ALU_PASSB; alusrc_c = 1'b1; sign_c = SIGN_IW;
      end
`endif
      default: ;
    endcase
  end

  // Moore outputs per state; ALU controls only in EXEC and MEM
  always_comb begin
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src   = 1'b0;
    reg2loc  = 1'b0;
    alusrc   = 1'b0;
    mem2reg  = 1'b0;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    aluop    = '0;
    signop   = '0;
    illegal  = 1'b0;
    case (state_q)
      ST_FETCH: ir_write = fetch_fire;
      ST_EXEC: begin
        aluop   = ALUOP_W'(alu_op_c);
        signop  = sign_c;
        reg2loc = reg2loc_c;
        alusrc  = alusrc_c;
        if (op_class == CLS_B) begin
          pc_src   = 1'b1;
          pc_write = 1'b1;
        end else if (op_class == CLS_CBZ) begin
          pc_src   = zero;
          pc_write = 1'b1;
        end
      end
      ST_MEM: begin
        aluop    = ALUOP_W'(alu_op_c);
        signop   = sign_c;
        reg2loc  = reg2loc_c;
        alusrc   = alusrc_c;
        memread  = (op_class == CLS_LDUR);
        memwrite = (op_class == CLS_STUR);
        pc_write = (op_class == CLS_STUR) && mem_ready;
      end
      ST_WB: begin
        regwrite = 1'b1;
        mem2reg  = (op_class == CLS_LDUR);
        pc_write = 1'b1;
      end
      ST_FAULT: illegal = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. A reference model expands each
// instruction into an expected per-cycle trace (inputs to apply plus outputs
// to expect) from the instruction class rules; tasks play the traces.
module tb_multicycle_control;
  import legv8_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        resetl = 1'b0;
  logic [10:0] opcode = '0;
  logic        instr_valid = 1'b0, mem_ready = 1'b0, zero = 1'b0;
  logic        ir_write, pc_write, pc_src, reg2loc, alusrc, mem2reg;
  logic        regwrite, memread, memwrite, illegal;
  logic [3:0]  aluop;
  logic [2:0]  signop, state;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam int TMO = 15;
  localparam int CL_B = 1, CL_CBZ = 2, CL_LDUR = 3, CL_STUR = 9, CL_ILL = 11;

  typedef struct packed {
    logic [2:0] st;
    logic ill, irw, pcw, pcs, r2l, asrc, m2r, rw, mr, mw;
    logic [3:0] aop;
    logic [2:0] sop;
  } obs_t;

  typedef struct {
    obs_t        o;
    logic        rst;
    logic        iv;
    logic [10:0] opc;
    logic        z;
    logic        mrdy;
  } ent_t;

  ent_t tq[$];

  multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
    .CLK(CLK), .resetl(resetl), .opcode(opcode), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .zero(zero), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg2loc(reg2loc), .alusrc(alusrc), .mem2reg(mem2reg),
    .regwrite(regwrite), .memread(memread), .memwrite(memwrite), .aluop(aluop),
    .signop(signop), .state(state), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  // Reference classification: pattern table walked in priority order
  function automatic int cls_of(input logic [10:0] opc);
    logic [10:0] val [11];
    logic [10:0] msk [11];
    val = '{11'b11010001000, 11'b00010100000, 11'b10110100000, 11'b11111000010,
            11'b10001010000, 11'b10101010000, 11'b10001011000, 11'b11001011000,
            11'b10010001000, 11'b11111000000, 11'b11010010100};
    msk = '{11'h7FE, 11'h7E0, 11'h7F8, 11'h7FF, 11'h7FF, 11'h7FF,
            11'h7FF, 11'h7FF, 11'h7FE, 11'h7FF, 11'h7FC};
    for (int k = 0; k < 11; k++) begin
      if ((opc & msk[k]) == val[k]) begin
`ifndef MULTICYCLE_CTRL_MOVZ_EN
        if (k == 10) return CL_ILL;
`endif
        return k;
      end
    end
    return CL_ILL;
  endfunction

  // Class order: SUBI B CBZ LDUR AND ORR ADD SUB ADDI STUR MOVZ ILL
  function automatic obs_t alu_fields(input int c);
    logic [3:0] aop_t [12];
    logic [2:0] sop_t [12];
    logic       r2l_t [12];
    logic       asrc_t [12];
    obs_t o;
    aop_t  = '{4'h6, 4'h0, 4'h7, 4'h2, 4'h0, 4'h1, 4'h2, 4'h6, 4'h2, 4'h2, 4'h7, 4'h0};
    sop_t  = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd4, 3'd0};
    r2l_t  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    asrc_t = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    o = '0;
    o.aop = aop_t[c];
    o.sop = sop_t[c];
    o.r2l = r2l_t[c];
    o.asrc = asrc_t[c];
    return o;
  endfunction

  function automatic ent_t rnd_in();
    ent_t e;
    e.o = '0;
    e.rst = 1'b0;
    e.iv = 1'($urandom);
    e.opc = 11'($urandom);
    e.z = 1'($urandom);
    e.mrdy = 1'($urandom);
    return e;
  endfunction

  task automatic add_idle(input int n);
    ent_t e;
    for (int k = 0; k < n; k++) begin
      e = rnd_in();
      e.iv = 1'b0;
      tq.push_back(e);
    end
  endtask

  // Two reset cycles then the first cycle after release: no strobes at all
  task automatic add_reset();
    ent_t e;
    for (int k = 0; k < 3; k++) begin
      e = rnd_in();
      e.iv = 1'b1;
      e.rst = (k < 2);
      tq.push_back(e);
    end
  endtask

  task automatic add_fault_hold(input int n);
    ent_t e;
    for (int k = 0; k < n; k++) begin
      e = rnd_in();
      e.o.st = 3'd5;
      e.o.ill = 1'b1;
      tq.push_back(e);
    end
  endtask

  // Expand one instruction into its expected cycle sequence
  task automatic add_instr(input logic [10:0] opc, input logic zero_v,
                           input int wait_n, output bit faulted);
    ent_t e;
    int c;
    c = cls_of(opc);
    faulted = 1'b0;
    e = rnd_in(); e.iv = 1'b1; e.opc = opc; e.o.irw = 1'b1;
    tq.push_back(e);
    e = rnd_in(); e.o.st = 3'd1;
    tq.push_back(e);
    if (c == CL_ILL) begin
      add_fault_hold(1);
      faulted = 1'b1;
      return;
    end
    e = rnd_in(); e.o = alu_fields(c); e.o.st = 3'd2;
    if (c == CL_B) begin
      e.o.pcw = 1'b1; e.o.pcs = 1'b1;
    end else if (c == CL_CBZ) begin
      e.z = zero_v; e.o.pcw = 1'b1; e.o.pcs = zero_v;
    end
    tq.push_back(e);
    if (c == CL_B || c == CL_CBZ) return;
    if (c == CL_LDUR || c == CL_STUR) begin
      for (int k = 0; k < TMO; k++) begin
        e = rnd_in(); e.o = alu_fields(c); e.o.st = 3'd3;
        e.mrdy = (k == wait_n);
        e.o.mr = (c == CL_LDUR);
        e.o.mw = (c == CL_STUR);
        e.o.pcw = (c == CL_STUR) && e.mrdy;
        tq.push_back(e);
        if (e.mrdy) break;
        if (k == TMO - 1) begin
          add_fault_hold(1);
          faulted = 1'b1;
          return;
        end
      end
      if (c == CL_STUR) return;
    end
    e = rnd_in(); e.o.st = 3'd4;
    e.o.rw = 1'b1; e.o.pcw = 1'b1; e.o.m2r = (c == CL_LDUR);
    tq.push_back(e);
  endtask

  // Apply one trace entry's inputs, sample outputs mid-cycle, advance a clock
  task automatic drive_cycle(input ent_t e, output obs_t obs);
    resetl = ~e.rst;
    instr_valid = e.iv;
    opcode = e.opc;
    zero = e.z;
    mem_ready = e.mrdy;
    @(negedge CLK);
    obs.st = state; obs.ill = illegal; obs.irw = ir_write; obs.pcw = pc_write;
    obs.pcs = pc_src; obs.r2l = reg2loc; obs.asrc = alusrc; obs.m2r = mem2reg;
    obs.rw = regwrite; obs.mr = memread; obs.mw = memwrite;
    obs.aop = aluop; obs.sop = signop;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    obs_t obs;
    add_reset();
    add_idle(2);
    foreach (tq[i]) begin
      drive_cycle(tq[i], obs);
      total_cnt++;
      if (obs !== tq[i].o) $display("FAIL reset cyc%0d: got %h, expected %h", i, obs, tq[i].o);
      else pass_cnt++;
    end
    tq.delete();
  endtask

  task automatic test_add();
    obs_t obs;
    bit f;
    add_idle(1);
    add_instr(11'h458, 1'b0, 0, f);
    add_instr(11'h458, 1'b0, 0, f);
    foreach (tq[i]) begin
      drive_cycle(tq[i], obs);
      total_cnt++;
      if (obs !== tq[i].o) $display("FAIL add cyc%0d: got %h, expected %h", i, obs, tq[i].o);
      else pass_cnt++;
    end
    tq.delete();
  endtask

  task automatic test_ldur_wait();
    obs_t obs;
    bit f;
    add_instr(11'h7C2, 1'b0, 3, f);
    add_instr(11'h7C2, 1'b0, 0, f);
    foreach (tq[i]) begin
      drive_cycle(tq[i], obs);
      total_cnt++;
      if (obs !== tq[i].o) $display("FAIL ldur cyc%0d: got %h, expected %h", i, obs, tq[i].o);
      else pass_cnt++;
    end
    tq.delete();
  endtask

  task automatic test_cbz();
    obs_t obs;
    bit f;
    add_instr(11'h5A0, 1'b1, 0, f);
    add_instr(11'h5A0, 1'b0, 0, f);
    add_instr(11'h0A5, 1'b0, 0, f);
    foreach (tq[i]) begin
      drive_cycle(tq[i], obs);
      total_cnt++;
      if (obs !== tq[i].o) $display("FAIL cbz cyc%0d: got %h, expected %h", i, obs, tq[i].o);
      else pass_cnt++;
    end
    tq.delete();
  endtask

  task automatic test_illegal();
    obs_t obs;
    bit f;
    add_instr(11'h000, 1'b0, 0, f);
    add_fault_hold(8);
    add_reset();
    add_instr(11'h458, 1'b0, 0, f);
    foreach (tq[i]) begin
      drive_cycle(tq[i], obs);
      total_cnt++;
      if (obs !== tq[i].o) $display("FAIL illegal cyc%0d: got %h, expected %h", i, obs, tq[i].o);
      else pass_cnt++;
    end
    tq.delete();
  endtask

  task automatic test_mem_timeout();
    obs_t obs;
    bit f;
    add_instr(11'h7C0, 1'b0, 1000, f);
    add_fault_hold(3);
    add_reset();
    add_instr(11'h7C0, 1'b0, TMO - 1, f);
    add_instr(11'h7C2, 1'b0, TMO, f);
    add_reset();
    add_instr(11'h7C0, 1'b0, 0, f);
    foreach (tq[i]) begin
      drive_cycle(tq[i], obs);
      total_cnt++;
      if (obs !== tq[i].o) $display("FAIL mem_timeout cyc%0d: got %h, expected %h", i, obs, tq[i].o);
      else pass_cnt++;
    end
    tq.delete();
  endtask

  task automatic test_movz();
    obs_t obs;
    bit f;
    add_instr(11'h694, 1'b0, 0, f);
    if (f) add_reset();
    add_instr(11'h697, 1'b0, 0, f);
    if (f) add_reset();
    add_instr(11'h688, 1'b0, 0, f);
    foreach (tq[i]) begin
      drive_cycle(tq[i], obs);
      total_cnt++;
      if (obs !== tq[i].o) $display("FAIL movz cyc%0d: got %h, expected %h", i, obs, tq[i].o);
      else pass_cnt++;
    end
    tq.delete();
  endtask

  task automatic test_reset_mid();
    obs_t obs;
    bit f;
    add_instr(11'h7C2, 1'b0, 6, f);
    tq = tq[0:3];
    add_reset();
    add_instr(11'h458, 1'b0, 0, f);
    foreach (tq[i]) begin
      drive_cycle(tq[i], obs);
      total_cnt++;
      if (obs !== tq[i].o) $display("FAIL reset_mid cyc%0d: got %h, expected %h", i, obs, tq[i].o);
      else pass_cnt++;
    end
    tq.delete();
  endtask

  task automatic test_back_to_back();
    obs_t obs;
    bit f;
    logic [10:0] pool [10];
    logic [10:0] opc;
    int w;
    pool = '{11'h458, 11'h658, 11'h450, 11'h550, 11'h488, 11'h688,
             11'h7C2, 11'h7C0, 11'h5A0, 11'h0A0};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) opc = 11'($urandom);
      else opc = pool[$urandom_range(0, 9)] | 11'($urandom_range(0, 1));
      w = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) add_idle($urandom_range(1, 2));
      add_instr(opc, 1'($urandom), w, f);
      if (f) add_reset();
    end
    foreach (tq[i]) begin
      drive_cycle(tq[i], obs);
      total_cnt++;
      if (obs !== tq[i].o) $display("FAIL random cyc%0d: got %h, expected %h", i, obs, tq[i].o);
      else pass_cnt++;
    end
    tq.delete();
  endtask

  initial begin
    @(posedge CLK);
    #1;
    test_reset();
    test_add();
    test_ldur_wait();
    test_cbz();
    test_illegal();
    test_mem_timeout();
    test_movz();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
